// File: rtl/mem_burst_ctrl.sv
// Burst controller: moves a counted run of words between a valid/ready stream
// and a single-word request/done memory port, with address wrap and a DNE timeout.
module mem_burst_ctrl #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH  = 4194304,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  Burst_Clk,
  input  logic                  Burst_Reset_n,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Dir,
  input  logic [BUS_WIDTH-1:0]  Cmd_Addr,
  input  logic [BUS_WIDTH-1:0]  Cmd_Words,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  input  logic                  Wr_Valid,
  output logic                  Wr_Ready,
  output logic [DATA_WIDTH-1:0] Rd_Data,
  output logic                  Rd_Valid,
  input  logic                  Rd_Ready,
  output logic [1:0]            Mem_Req_Sel,
  output logic                  Mem_En,
  output logic [BUS_WIDTH-1:0]  Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_Wr_Data,
  input  logic [DATA_WIDTH-1:0] Mem_Rd_Data,
  input  logic                  Mem_DNE,
  output logic                  Burst_Busy,
  output logic                  Burst_Done,
  output logic                  Burst_Err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BUS_WIDTH-1:0] DEPTH     = BUS_WIDTH'(MEM_DEPTH);
  localparam logic [BUS_WIDTH-1:0] LAST_ADDR = BUS_WIDTH'(MEM_DEPTH - 1);
  localparam logic [TW-1:0]        WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [BUS_WIDTH-1:0]  addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  remain_q, remain_d;
  logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  wr_ready_q, wr_ready_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [1:0]            sel_q, sel_d;
  logic                  mem_en_q, mem_en_d;
  logic [BUS_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  issue;
  logic [BUS_WIDTH-1:0]  addr_inc;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    wait_cnt_d    = wait_cnt_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    sel_d         = sel_q;
    mem_en_d      = mem_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    err_d         = err_q;
    issue         = 1'b0;
    addr_inc      = (addr_q == LAST_ADDR) ? '0 : addr_q + BUS_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (Cmd_Valid && cmd_ready_q) begin
          dir_d    = Cmd_Dir;
          addr_d   = Cmd_Addr;
          remain_d = Cmd_Words;
          err_d    = 1'b0;
          if (Cmd_Words == '0) begin
            state_d = DONE;
          end else if (Cmd_Addr >= DEPTH) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (dir_q) begin
          issue = 1'b1;
        end else if (Wr_Valid && wr_ready_q) begin
          issue         = 1'b1;
          mem_wr_data_d = Wr_Data;
        end
        if (issue) begin
          mem_addr_d = addr_q;
          sel_d      = {1'b1, dir_q};
          mem_en_d   = 1'b1;
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (Mem_DNE) begin
          mem_en_d = 1'b0;
          addr_d   = addr_inc;
          remain_d = remain_q - BUS_WIDTH'(1);
          if (dir_q) begin
            rd_data_d  = Mem_Rd_Data;
            rd_valid_d = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = (remain_q == BUS_WIDTH'(1)) ? DONE : ISSUE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Memory never answered: abandon the rest of the burst
          mem_en_d = 1'b0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      HOLD: begin
        if (rd_valid_q && Rd_Ready) begin
          rd_valid_d = 1'b0;
          state_d    = (remain_q == '0) ? DONE : ISSUE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == ISSUE) && !dir_d;
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == DONE);
  end

  // State and output registers
  always_ff @(posedge Burst_Clk or negedge Burst_Reset_n) begin
    if (!Burst_Reset_n) begin
      state_q       <= IDLE;
      dir_q         <= 1'b0;
      addr_q        <= '0;
      remain_q      <= '0;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      sel_q         <= 2'b00;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_ready_q    <= wr_ready_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      sel_q         <= sel_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign Cmd_Ready   = cmd_ready_q;
  assign Wr_Ready    = wr_ready_q;
  assign Rd_Data     = rd_data_q;
  assign Rd_Valid    = rd_valid_q;
  assign Mem_Req_Sel = sel_q;
  assign Mem_En      = mem_en_q;
  assign Mem_Addr    = mem_addr_q;
  assign Mem_Wr_Data = mem_wr_data_q;
  assign Burst_Busy  = busy_q;
  assign Burst_Done  = done_q;
  assign Burst_Err   = err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Randomized bench for mem_burst_ctrl: memory responder, stream source/sink,
// and an address/data model of each burst built from the command alone.
module tb_mem_burst_ctrl;

  localparam int unsigned MEM_DEPTH = 4194304;
  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  logic        Burst_Clk, Burst_Reset_n;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Dir;
  logic [31:0] Cmd_Addr, Cmd_Words;
  logic [23:0] Wr_Data;
  logic        Wr_Valid, Wr_Ready;
  logic [23:0] Rd_Data;
  logic        Rd_Valid, Rd_Ready;
  logic [1:0]  Mem_Req_Sel;
  logic        Mem_En;
  logic [31:0] Mem_Addr;
  logic [23:0] Mem_Wr_Data, Mem_Rd_Data;
  logic        Mem_DNE;
  logic        Burst_Busy, Burst_Done, Burst_Err;

  mem_burst_ctrl dut (
    .Burst_Clk(Burst_Clk), .Burst_Reset_n(Burst_Reset_n),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Dir(Cmd_Dir),
    .Cmd_Addr(Cmd_Addr), .Cmd_Words(Cmd_Words),
    .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
    .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready),
    .Mem_Req_Sel(Mem_Req_Sel), .Mem_En(Mem_En), .Mem_Addr(Mem_Addr),
    .Mem_Wr_Data(Mem_Wr_Data), .Mem_Rd_Data(Mem_Rd_Data), .Mem_DNE(Mem_DNE),
    .Burst_Busy(Burst_Busy), .Burst_Done(Burst_Done), .Burst_Err(Burst_Err)
  );

  initial Burst_Clk = 1'b0;
  always #5 Burst_Clk = ~Burst_Clk;

  int checks = 0;
  int fails  = 0;

  // Environment controls and observations
  bit          dne_en = 1'b1, lat_rand = 1'b0, noise = 1'b0;
  bit          wr_rand = 1'b0, rd_rand = 1'b0, cur_rd = 1'b0;
  int          lat_fix = 1, lat = 1, lat_cnt = 0, stall_left = 0;
  int          done_cnt = 0, en_run = 0, last_run = 0;
  bit          en_prev = 1'b0, wr_hs = 1'b0, rd_stalled = 1'b0;
  logic [23:0] rd_prev;
  logic [31:0] mon_addr_q[$];
  logic [23:0] mon_data_q[$];
  logic [1:0]  mon_sel_q[$];
  logic [23:0] mon_rd_q[$];
  logic [23:0] wr_q[$];

  function automatic logic [23:0] pat(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[31:8] ^ a[23:0];
  endfunction

  // Monitor at negedge, drive memory/stream side just after posedge
  initial begin : bfm
    Mem_DNE = 1'b0; Mem_Rd_Data = '0; Wr_Valid = 1'b0; Wr_Data = '0; Rd_Ready = 1'b0;
    forever begin
      @(negedge Burst_Clk);
      if (Mem_En && !en_prev) begin
        mon_addr_q.push_back(Mem_Addr);
        mon_data_q.push_back(Mem_Wr_Data);
        mon_sel_q.push_back(Mem_Req_Sel);
      end
      if (Mem_En) en_run++;
      else if (en_run > 0) begin last_run = en_run; en_run = 0; end
      en_prev = Mem_En;
      if (Burst_Done) done_cnt++;
      if (Rd_Valid && Rd_Ready) mon_rd_q.push_back(Rd_Data);
      if (Rd_Valid) begin
        checks++;
        if (Mem_En) begin fails++; $display("FAIL rd_hold_no_issue: Mem_En=%0b required 0 at %0t", Mem_En, $time); end
      end
      if (rd_stalled) begin
        checks++;
        if (Rd_Valid !== 1'b1 || Rd_Data !== rd_prev) begin
          fails++;
          $display("FAIL rd_stall_stable: valid=%0b data=%h required 1/%h", Rd_Valid, Rd_Data, rd_prev);
        end
      end
      if (cur_rd) begin
        checks++;
        if (Wr_Ready !== 1'b0) begin fails++; $display("FAIL wr_ready_in_read: got %0b required 0", Wr_Ready); end
      end
      rd_stalled = Rd_Valid && !Rd_Ready;
      rd_prev    = Rd_Data;
      wr_hs      = Wr_Valid && Wr_Ready;

      @(posedge Burst_Clk); #1;
      if (Mem_En && dne_en) begin
        if (lat_cnt >= lat) begin
          Mem_DNE = 1'b1; Mem_Rd_Data = pat(Mem_Addr); lat_cnt = 0;
          lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
        end else begin
          Mem_DNE = 1'b0; lat_cnt++;
        end
      end else begin
        Mem_DNE = noise && !Mem_En && ($urandom_range(0, 3) == 0);
        Mem_Rd_Data = 24'($urandom);
        lat_cnt = 0;
        lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
      end
      if (wr_hs && wr_q.size() > 0) wr_q.delete(0);
      if (wr_q.size() > 0) begin
        Wr_Data = wr_q[0];
        Wr_Valid = wr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        Wr_Valid = 1'b0; Wr_Data = '0;
      end
      if (stall_left > 0 && Rd_Valid) begin Rd_Ready = 1'b0; stall_left--; end
      else Rd_Ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge Burst_Clk); #2;
  endtask

  task automatic clear_mon();
    mon_addr_q.delete(); mon_data_q.delete(); mon_sel_q.delete(); mon_rd_q.delete();
  endtask

  task automatic send_cmd(input logic dir, input logic [31:0] addr, input logic [31:0] words, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (Cmd_Ready) ok = 1'b1; else cyc();
    end
    Cmd_Valid = 1'b1; Cmd_Dir = dir; Cmd_Addr = addr; Cmd_Words = words;
    cyc();
    Cmd_Valid = 1'b0; Cmd_Addr = $urandom; Cmd_Words = $urandom; Cmd_Dir = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc();
      if (done_cnt != d0) ok = 1'b1;
    end
  endtask

  // Full burst against a model built from the command: word i lives at (addr+i) mod depth
  task automatic run_burst(input logic dir, input logic [31:0] addr, input logic [31:0] words, input string nm);
    logic [31:0] exp_addr[$];
    logic [23:0] exp_dat[$];
    logic [31:0] a;
    logic [23:0] w;
    bit exp_err, ok;
    int d0;
    clear_mon();
    exp_err = (words != 0) && (addr >= DEPTH);
    if (words != 0 && !exp_err) begin
      for (int i = 0; i < int'(words); i++) begin
        a = 32'((64'(addr) + 64'(i)) % 64'(MEM_DEPTH));
        exp_addr.push_back(a);
        if (dir) exp_dat.push_back(pat(a));
        else begin w = 24'($urandom); exp_dat.push_back(w); wr_q.push_back(w); end
      end
    end
    cur_rd = dir;
    d0 = done_cnt;
    send_cmd(dir, addr, words, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL %s_accept: Cmd_Ready never rose", nm); end
    wait_done(3000, d0, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL %s_done_timeout: no Burst_Done within budget", nm); end
    repeat (3) cyc();
    cur_rd = 1'b0;
    checks++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL %s_done_count: got %0d required 1", nm, done_cnt - d0); end
    checks++;
    if (Burst_Err !== exp_err) begin fails++; $display("FAIL %s_err: got %0b required %0b", nm, Burst_Err, exp_err); end
    checks++;
    if (Burst_Busy !== 1'b0) begin fails++; $display("FAIL %s_busy_after: got %0b required 0", nm, Burst_Busy); end
    checks++;
    if (mon_addr_q.size() != exp_addr.size()) begin
      fails++; $display("FAIL %s_access_count: got %0d required %0d", nm, mon_addr_q.size(), exp_addr.size());
    end
    if (dir) begin
      checks++;
      if (mon_rd_q.size() != exp_dat.size()) begin
        fails++; $display("FAIL %s_rd_count: got %0d required %0d", nm, mon_rd_q.size(), exp_dat.size());
      end
    end
    for (int i = 0; i < exp_addr.size() && i < mon_addr_q.size(); i++) begin
      checks++;
      if (mon_addr_q[i] !== exp_addr[i] || mon_sel_q[i] !== {1'b1, dir}) begin
        fails++;
        $display("FAIL %s_addr[%0d]: got %h sel %b required %h sel %b", nm, i, mon_addr_q[i], mon_sel_q[i], exp_addr[i], {1'b1, dir});
      end
      checks++;
      if (dir) begin
        if (i < mon_rd_q.size() && mon_rd_q[i] !== exp_dat[i]) begin
          fails++; $display("FAIL %s_rd_data[%0d]: got %h required %h", nm, i, mon_rd_q[i], exp_dat[i]);
        end
      end else if (mon_data_q[i] !== exp_dat[i]) begin
        fails++; $display("FAIL %s_wr_data[%0d]: got %h required %h", nm, i, mon_data_q[i], exp_dat[i]);
      end
    end
    if (exp_addr.size() > 0) begin
      checks++;
      if (Mem_Req_Sel !== {1'b1, dir}) begin
        fails++; $display("FAIL %s_sel_hold: got %b required %b", nm, Mem_Req_Sel, {1'b1, dir});
      end
    end
  endtask

  task automatic test_reset();
    Burst_Reset_n = 1'b0; Cmd_Valid = 1'b0; Cmd_Dir = 1'b0; Cmd_Addr = '0; Cmd_Words = '0;
    repeat (3) cyc();
    checks++;
    if ({Cmd_Ready, Wr_Ready, Rd_Valid, Mem_En, Burst_Busy, Burst_Done, Burst_Err} !== 7'b0) begin
      fails++; $display("FAIL reset_flags: got %b required 0000000",
        {Cmd_Ready, Wr_Ready, Rd_Valid, Mem_En, Burst_Busy, Burst_Done, Burst_Err});
    end
    checks++;
    if (Mem_Req_Sel !== 2'b00 || Mem_Addr !== '0) begin
      fails++; $display("FAIL reset_mem_bus: sel %b addr %h required 00/0", Mem_Req_Sel, Mem_Addr);
    end
    checks++;
    if (Mem_Wr_Data !== '0 || Rd_Data !== '0) begin
      fails++; $display("FAIL reset_data: wr %h rd %h required 0/0", Mem_Wr_Data, Rd_Data);
    end
    Burst_Reset_n = 1'b1;
    checks++;
    if (Cmd_Ready !== 1'b0) begin fails++; $display("FAIL reset_ready_before_edge: got %0b required 0", Cmd_Ready); end
    cyc();
    checks++;
    if (Cmd_Ready !== 1'b1) begin fails++; $display("FAIL reset_ready_first_edge: got %0b required 1", Cmd_Ready); end
  endtask

  task automatic test_write_basic();
    lat_fix = 1;
    run_burst(1'b0, 32'h10, 32'd3, "wr_basic");
  endtask

  task automatic test_read_wrap();
    lat_fix = 1; stall_left = 5;
    run_burst(1'b1, DEPTH - 32'd2, 32'd3, "rd_wrap");
    stall_left = 0;
  endtask

  task automatic test_zero_words();
    bit ok;
    clear_mon();
    send_cmd(1'b0, 32'h20, 32'd0, ok);
    checks++;
    if (Burst_Done !== 1'b0 || Burst_Busy !== 1'b1) begin
      fails++; $display("FAIL zero_accept_edge: done %0b busy %0b required 0/1", Burst_Done, Burst_Busy);
    end
    cyc();
    checks++;
    if (Burst_Done !== 1'b1) begin fails++; $display("FAIL zero_done_pulse: got %0b required 1", Burst_Done); end
    cyc();
    checks++;
    if (Burst_Done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %0b required 0", Burst_Done); end
    checks++;
    if (mon_addr_q.size() != 0) begin fails++; $display("FAIL zero_no_access: got %0d required 0", mon_addr_q.size()); end
  endtask

  task automatic test_addr_err();
    run_burst(1'b1, DEPTH, 32'd4, "addr_err");
  endtask

  task automatic test_timeout();
    bit ok;
    int d0;
    clear_mon();
    dne_en = 1'b0;
    wr_q.push_back(24'h111111); wr_q.push_back(24'h222222);
    d0 = done_cnt;
    send_cmd(1'b0, 32'h5, 32'd2, ok);
    wait_done(1000, d0, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL to_done_timeout: no Burst_Done within budget"); end
    repeat (2) cyc();
    checks++;
    if (last_run != 255) begin fails++; $display("FAIL to_en_cycles: got %0d required 255", last_run); end
    checks++;
    if (Burst_Err !== 1'b1) begin fails++; $display("FAIL to_err: got %0b required 1", Burst_Err); end
    checks++;
    if (mon_addr_q.size() != 1 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL to_abandon: accesses %0d dones %0d required 1/1", mon_addr_q.size(), done_cnt - d0);
    end
    wr_q.delete();
    dne_en = 1'b1;
    send_cmd(1'b0, 32'h5, 32'd0, ok);
    checks++;
    if (Burst_Err !== 1'b0) begin fails++; $display("FAIL to_err_clear: got %0b required 0", Burst_Err); end
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int d0;
    clear_mon();
    lat_fix = 3;
    for (int i = 0; i < 3; i++) wr_q.push_back(24'($urandom));
    d0 = done_cnt;
    send_cmd(1'b0, 32'h40, 32'd3, ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cyc();
      if (mon_addr_q.size() >= 2) ok = 1'b1;
    end
    checks++;
    if (!ok || Mem_En !== 1'b1 || mon_addr_q[1] !== 32'h41) begin
      fails++; $display("FAIL rst_mid_reach_word2: en %0b accesses %0d required 1/2", Mem_En, mon_addr_q.size());
    end
    Burst_Reset_n = 1'b0;
    #1;
    checks++;
    if (Mem_En !== 1'b0) begin fails++; $display("FAIL rst_mid_en_async: got %0b required 0", Mem_En); end
    checks++;
    if ({Burst_Busy, Cmd_Ready, Wr_Ready, Burst_Done} !== 4'b0 || Mem_Addr !== '0 || Mem_Req_Sel !== 2'b00) begin
      fails++; $display("FAIL rst_mid_outputs: flags %b addr %h sel %b required 0000/0/00",
        {Burst_Busy, Cmd_Ready, Wr_Ready, Burst_Done}, Mem_Addr, Mem_Req_Sel);
    end
    wr_q.delete();
    cyc(); cyc();
    Burst_Reset_n = 1'b1;
    checks++;
    if (Cmd_Ready !== 1'b0) begin fails++; $display("FAIL rst_mid_ready_early: got %0b required 0", Cmd_Ready); end
    cyc();
    checks++;
    if (Cmd_Ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready_edge: got %0b required 1", Cmd_Ready); end
    repeat (3) cyc();
    checks++;
    if (done_cnt != d0) begin fails++; $display("FAIL rst_mid_no_done: got %0d pulses required 0", done_cnt - d0); end
    lat_fix = 1;
  endtask

  task automatic test_random();
    logic [31:0] addr, words;
    logic dir;
    lat_rand = 1'b1; noise = 1'b1; wr_rand = 1'b1; rd_rand = 1'b1;
    for (int n = 0; n < 14; n++) begin
      dir   = 1'($urandom);
      words = 32'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: addr = DEPTH - 32'($urandom_range(1, 4));
        1: addr = 32'($urandom_range(0, 1000));
        2: addr = DEPTH + 32'($urandom_range(0, 3));
        default: addr = 32'($urandom) & 32'h003F_FFFF;
      endcase
      run_burst(dir, addr, words, "rand");
    end
    lat_rand = 1'b0; noise = 1'b0; wr_rand = 1'b0; rd_rand = 1'b0;
  endtask

  initial begin : main
    Burst_Reset_n = 1'b0;
    Cmd_Valid = 1'b0; Cmd_Dir = 1'b0; Cmd_Addr = '0; Cmd_Words = '0;
    test_reset();
    test_write_basic();
    test_read_wrap();
    test_zero_words();
    test_addr_err();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
